fp_alu_issuer: RTL and testbench
================================

Name: fp_alu_issuer

Overview:
- Command-side driver for the 32-bit floating-point ALU (adder/multiplier pair selected by a 1-bit opcode).
- Accepts tagged operations over a ready/valid command port, buffers them in a small FIFO, and issues one at a time as a single-cycle i_vld pulse.
- Holds the opcode stable until the matching result-valid returns, because the ALU output mux follows the live opcode.
- Returns result, overflow and tag on a ready/valid response port, with a timeout guard.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
- TAG_W, 4, width of the user tag carried from command to response
- TIMEOUT, 64, maximum WAIT cycles before the op is abandoned (>=2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready (FIFO not full)
- cmd_a  in  32  operand A, IEEE-754 single
- cmd_b  in  32  operand B, IEEE-754 single
- cmd_op  in  1  0=add, 1=multiply
- cmd_tag  in  TAG_W  user tag
- alu_vld  out  1  to ALU i_vld
- alu_a  out  32  to ALU i_a
- alu_b  out  32  to ALU i_b
- alu_op  out  1  to ALU opcode
- alu_res  in  32  from ALU o_res
- alu_res_vld  in  1  from ALU o_res_vld
- alu_ovf  in  1  from ALU overflow
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_res  out  32  result
- rsp_ovf  out  1  overflow flag captured with result
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_timeout  out  1  1 = op abandoned; rsp_res forced to 0
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (rst=0, async): FSM=IDLE, FIFO empty, timeout counter 0. All outputs 0 except cmd_rdy=1.
- FIFO:
  - push when cmd_vld&&cmd_rdy; cmd_rdy = (count != FIFO_DEPTH), registered count.
  - no same-cycle bypass when full.
  - simultaneous push+pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
- IDLE: if FIFO non-empty, pop head into op registers (a, b, op, tag) -> ISSUE.
- ISSUE (1 cycle): alu_vld=1; alu_a/alu_b/alu_op driven from op registers; counter cleared -> WAIT. alu_res_vld in this cycle is ignored (stale).
- WAIT:
  - alu_vld=0; alu_a/alu_b/alu_op held.
  - on alu_res_vld=1: capture alu_res->rsp_res and alu_ovf->rsp_ovf, rsp_timeout=0 -> RESP.
  - else counter++; when counter==TIMEOUT-1 without valid: rsp_res=0, rsp_ovf=0, rsp_timeout=1 -> RESP.
  - valid on the timeout cycle wins (normal capture).
- RESP:
  - rsp_vld=1; rsp_res/ovf/tag/timeout stable until rsp_rdy=1.
  - handshake -> IDLE, rsp_vld=0 next cycle.
  - alu_res_vld is ignored outside WAIT.
- alu_op keeps its last value in RESP/IDLE and changes only when a new op is loaded.
- Latency: command accepted at edge N -> popped in cycle N+1 -> alu_vld high in cycle N+2 (FIFO empty, FSM idle). Result-valid in cycle M -> rsp_vld in cycle M+1.
- Exactly one op outstanding; the next issue is no earlier than 2 cycles after the response handshake.
- Reset mid-operation discards FIFO contents and the in-flight op; no response is produced for them.

Test Plan:
- Add: cmd_a=0x3F800000, cmd_b=0x40000000, op=0, tag=3; ALU model returns 0x40400000 3 cycles after i_vld -> alu_vld one cycle wide 2 cycles after accept; rsp_res=0x40400000, tag=3, ovf=0, timeout=0.
- Multiply: 0x40000000*0x40400000, op=1; model asserts stray alu_res_vld in the ISSUE cycle, real 0x40C00000 at +4 -> stray ignored; alu_op==1 every WAIT cycle; rsp_res=0x40C00000.
- FIFO full: ALU never responds; push 6 back-to-back -> first popped, 4 buffered, cmd_rdy=0 on the 6th; busy=1.
- Timeout (TIMEOUT=64): no alu_res_vld -> rsp_vld after 64 WAIT cycles with rsp_res=0, rsp_timeout=1; next FIFO entry then issues normally.
- Backpressure: rsp_rdy=0 for 10 cycles -> rsp_* stable and no alu_vld for queued cmds; release -> next issue 2 cycles later.
- Reset in WAIT: rst low -> all outputs 0, cmd_rdy=1; model's late alu_res_vld after release -> no rsp_vld.

Source files
------------

// File: rtl/fp_alu_issuer.sv
// Command-side issuer for the FP add/mul ALU: buffers tagged ops in a FIFO,
// issues one at a time, holds operands/opcode until the result returns, with a timeout guard.
module fp_alu_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_vld,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_op,
  input  logic [31:0]      alu_res,
  input  logic             alu_res_vld,
  input  logic             alu_ovf,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [31:0]      rsp_res,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  cmd_t          op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic          ovf_q, ovf_d, to_q, to_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push, pop;
  cmd_t          cmd_in;

  assign cmd_in  = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign cmd_rdy = (cnt_q != CW'(FIFO_DEPTH));
  assign push    = cmd_vld && cmd_rdy;
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0);

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d    = mem_q[rptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // any result-valid seen here belongs to an earlier op and is dropped
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_res_vld) begin
          res_d   = alu_res;
          ovf_d   = alu_ovf;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      op_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      tmo_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
    end
  end

  // storage needs no reset: entries are only read below the registered count
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_in;
  end

  assign alu_vld     = (state_q == S_ISSUE);
  assign alu_a       = op_q.a;
  assign alu_b       = op_q.b;
  assign alu_op      = op_q.op;
  assign rsp_vld     = (state_q == S_RESP);
  assign rsp_res     = res_q;
  assign rsp_ovf     = ovf_q;
  assign rsp_tag     = op_q.tag;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fp_alu_issuer.sv
// Bench for fp_alu_issuer: directed vectors, multi-cycle corner sequences, and a
// randomized run scored against an in-order transaction model.
module tb_fp_alu_issuer;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_vld = 1'b0, cmd_rdy, cmd_op = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_tag = '0;
  logic alu_vld, alu_op, alu_res_vld = 1'b0, alu_ovf = 1'b0;
  logic [31:0] alu_a, alu_b, alu_res = '0;
  logic rsp_vld, rsp_rdy = 1'b0, rsp_ovf, rsp_timeout, busy;
  logic [31:0] rsp_res;
  logic [3:0] rsp_tag;

  fp_alu_issuer #(.FIFO_DEPTH(4), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag), .alu_vld(alu_vld),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .alu_res_vld(alu_res_vld), .alu_ovf(alu_ovf), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .busy(busy));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stand-in ALU transfer function; only needs to be deterministic per operand set
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] r;
    r = op ? (a * b + 32'h5) : (a + b);
    return {r[31] ^ r[0] ^ op, r};
  endfunction

  // ALU responder: delay d counted in cycles after the i_vld cycle, 0 = never answers
  bit rnd_alu = 0, fix_stray = 0;
  int fix_d = 3, last_d = 0, cd = 0, fire_cyc = 0;
  logic [31:0] fix_res = '0, ra, rb;
  logic fix_ovf = 1'b0, rop;
  initial forever begin
    @(posedge clk); #1;
    alu_res_vld = 1'b0; alu_res = '0; alu_ovf = 1'b0;
    if (alu_vld) begin
      if (rnd_alu) begin
        last_d = ($urandom_range(0, 15) == 0) ? 0 :
                 ($urandom_range(0, 15) == 0) ? TIMEOUT : int'($urandom_range(1, 6));
      end else last_d = fix_d;
      cd = last_d; ra = alu_a; rb = alu_b; rop = alu_op;
      if (rnd_alu ? ($urandom_range(0, 3) == 0) : fix_stray) begin
        alu_res_vld = 1'b1; alu_res = 32'hDEADBEEF; alu_ovf = 1'b1;
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        alu_res_vld = 1'b1; fire_cyc = cyc;
        if (rnd_alu) {alu_ovf, alu_res} = alu_fn(ra, rb, rop);
        else begin alu_res = fix_res; alu_ovf = fix_ovf; end
      end
    end
  end

  bit rnd_rdy = 0, rdy_dir = 1;
  initial forever begin
    @(posedge clk); #2;
    rsp_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_dir;
  end

  // scoreboard for the randomized phase
  typedef struct {logic [31:0] a, b; logic op; logic [3:0] tag;} cmd_s;
  typedef struct {logic [31:0] res; logic ovf, to; logic [3:0] tag;} rsp_s;
  cmd_s cq[$];
  rsp_s rq[$];
  bit sb_en = 0;
  always @(negedge clk) if (sb_en) begin
    if (cmd_vld && cmd_rdy) cq.push_back('{cmd_a, cmd_b, cmd_op, cmd_tag});
    if (alu_vld) begin
      if (cq.size() == 0) check("sb_spurious_issue", 1, 0);
      else begin
        cmd_s c; rsp_s r; logic [32:0] f;
        c = cq.pop_front();
        check("sb_alu_a", alu_a, c.a);
        check("sb_alu_b", alu_b, c.b);
        check("sb_alu_op", alu_op, c.op);
        f = alu_fn(c.a, c.b, c.op);
        r.to = (last_d == 0) || (last_d > TIMEOUT);
        r.res = r.to ? 32'h0 : f[31:0];
        r.ovf = r.to ? 1'b0 : f[32];
        r.tag = c.tag;
        rq.push_back(r);
      end
    end
    if (rsp_vld && rsp_rdy) begin
      if (rq.size() == 0) check("sb_spurious_rsp", 1, 0);
      else begin
        rsp_s r;
        r = rq.pop_front();
        check("sb_rsp_res", rsp_res, r.res);
        check("sb_rsp_ovf", rsp_ovf, r.ovf);
        check("sb_rsp_tag", rsp_tag, r.tag);
        check("sb_rsp_to", rsp_timeout, r.to);
      end
    end
  end

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag);
    cmd_vld = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
  endtask

  task automatic wait_rsp(input string name, output int c);
    int k = 0;
    @(negedge clk);
    while (!rsp_vld && k < 300) begin @(negedge clk); k++; end
    if (!rsp_vld) check({name, "_rsp_timeout"}, 0, 1);
    c = cyc;
  endtask

  typedef struct {
    logic [31:0] a, b; logic op; logic [3:0] tag;
    logic [31:0] ret; logic rovf; int d; bit stray;
    logic [31:0] eres; logic eovf, eto;
  } vec_t;
  vec_t vt[6];

  task automatic run_one(input vec_t v, input int idx);
    int hs, iss, rc, k, bad;
    string nm;
    nm = $sformatf("v%0d", idx);
    fix_d = v.d; fix_res = v.ret; fix_ovf = v.rovf; fix_stray = v.stray;
    @(posedge clk); #1; drive_cmd(v.a, v.b, v.op, v.tag);
    @(negedge clk); check({nm, "_cmd_rdy"}, cmd_rdy, 1); hs = cyc;
    @(posedge clk); #1; cmd_vld = 1'b0;
    k = 0;
    @(negedge clk);
    while (!alu_vld && k < 10) begin @(negedge clk); k++; end
    iss = cyc;
    check({nm, "_issue_lat"}, iss - hs, 2);
    bad = 0;
    @(negedge clk);
    check({nm, "_vld_width"}, alu_vld, 0);
    k = 0;
    while (!rsp_vld && k < 200) begin
      if (alu_op !== v.op || alu_a !== v.a || alu_b !== v.b) bad++;
      @(negedge clk); k++;
    end
    rc = cyc;
    check({nm, "_op_held"}, bad, 0);
    check({nm, "_rsp_lat"}, rc, v.eto ? iss + TIMEOUT + 1 : fire_cyc + 1);
    check({nm, "_res"}, rsp_res, v.eres);
    check({nm, "_ovf"}, rsp_ovf, v.eovf);
    check({nm, "_tag"}, rsp_tag, v.tag);
    check({nm, "_to"}, rsp_timeout, v.eto);
    @(negedge clk);
    check({nm, "_rsp_drop"}, rsp_vld, 0);
  endtask

  initial begin
    int rc, hs, k, bad, acc, sent;
    logic rdy6;
    logic [38:0] snap;

    vt[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'h3, 32'h40400000, 1'b0, 3, 1'b0, 32'h40400000, 1'b0, 1'b0};
    vt[1] = '{32'h40000000, 32'h40400000, 1'b1, 4'h5, 32'h40C00000, 1'b0, 4, 1'b1, 32'h40C00000, 1'b0, 1'b0};
    vt[2] = '{32'h7F000000, 32'h7F000000, 1'b1, 4'hA, 32'h7F800000, 1'b1, 1, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vt[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 4'h7, 32'h11111111, 1'b1, 0, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vt[4] = '{32'h3E000000, 32'h3E000000, 1'b0, 4'hF, 32'h3E800000, 1'b0, TIMEOUT, 1'b0, 32'h3E800000, 1'b0, 1'b0};
    vt[5] = '{32'hBF800000, 32'h3F800000, 1'b0, 4'h0, 32'h00000000, 1'b1, 1, 1'b1, 32'h00000000, 1'b1, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_outs_zero", |{alu_vld, alu_a, alu_b, alu_op, rsp_vld, rsp_res, rsp_ovf,
                             rsp_tag, rsp_timeout, busy}, 0);
    @(posedge clk); #1; rst = 1'b1;

    for (int i = 0; i < 6; i++) run_one(vt[i], i);

    // FIFO full: first op times out, 4 buffered behind it, sixth push refused
    fix_d = 0; fix_stray = 0; fix_res = 32'h12345678; fix_ovf = 1'b0;
    acc = 0; rdy6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; drive_cmd(32'h1000 + i, 32'h2000 + i, 1'b0, 4'(i));
      @(negedge clk);
      if (cmd_rdy) acc++;
      if (i == 5) rdy6 = cmd_rdy;
    end
    @(posedge clk); #1; cmd_vld = 1'b0;
    check("full_accepted", acc, 5);
    check("full_rdy6", rdy6, 0);
    @(negedge clk); check("full_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("full%0d", i), rc);
      if (i == 0) fix_d = 2;
      check($sformatf("full%0d_tag", i), rsp_tag, 4'(i));
      check($sformatf("full%0d_to", i), rsp_timeout, i == 0);
      check($sformatf("full%0d_res", i), rsp_res, i == 0 ? 32'h0 : 32'h12345678);
      @(negedge clk);
    end
    @(negedge clk); check("full_idle", busy, 0);

    // response backpressure
    fix_d = 2; fix_res = 32'hCAFE0001; rdy_dir = 0;
    @(posedge clk); #1; drive_cmd(32'h1, 32'h2, 1'b1, 4'h1);
    @(posedge clk); #1; drive_cmd(32'h3, 32'h4, 1'b0, 4'h2);
    @(posedge clk); #1; cmd_vld = 1'b0;
    wait_rsp("bp", rc);
    snap = {rsp_res, rsp_ovf, rsp_tag, rsp_timeout, rsp_vld};
    check("bp_tag", rsp_tag, 4'h1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({rsp_res, rsp_ovf, rsp_tag, rsp_timeout, rsp_vld} !== snap || alu_vld) bad++;
    end
    check("bp_stable", bad, 0);
    @(posedge clk); #1; rdy_dir = 1;
    @(negedge clk); check("bp_hs", rsp_vld && rsp_rdy, 1); hs = cyc;
    k = 0;
    @(negedge clk);
    while (!alu_vld && k < 10) begin @(negedge clk); k++; end
    check("bp_next_issue", cyc - hs, 2);
    wait_rsp("bp2", rc);
    check("bp2_tag", rsp_tag, 4'h2);
    check("bp2_res", rsp_res, 32'hCAFE0001);
    @(negedge clk);

    // randomized run against the scoreboard
    sb_en = 1; rnd_alu = 1; rnd_rdy = 1; sent = 0;
    while (sent < 150) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) != 0) begin
        drive_cmd($urandom, $urandom, 1'($urandom), 4'($urandom));
        k = 0;
        @(negedge clk);
        while (!cmd_rdy && k < 1000) begin @(negedge clk); k++; end
        if (!cmd_rdy) check("rnd_push_stall", 0, 1);
        sent++;
      end else cmd_vld = 1'b0;
    end
    @(posedge clk); #1; cmd_vld = 1'b0;
    rnd_rdy = 0; rdy_dir = 1;
    k = 0;
    while ((busy || rq.size() != 0) && k < 3000) begin @(negedge clk); k++; end
    check("rnd_drained", {busy, 31'(rq.size()), 32'(cq.size())}, 0);
    sb_en = 0; rnd_alu = 0;

    // reset while waiting: late result must not produce a response
    fix_d = 5; fix_stray = 0;
    @(posedge clk); #1; drive_cmd(32'h55, 32'h66, 1'b1, 4'h9);
    @(posedge clk); #1; cmd_vld = 1'b0;
    k = 0;
    while (!alu_vld && k < 10) begin @(negedge clk); k++; end
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstw_cmd_rdy", cmd_rdy, 1);
    check("rstw_outs_zero", |{alu_vld, alu_a, alu_b, alu_op, rsp_vld, rsp_res, rsp_ovf,
                              rsp_tag, rsp_timeout, busy}, 0);
    @(posedge clk); #1; rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_vld || alu_vld || busy) bad++;
    end
    check("rstw_no_rsp", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
